// File: rtl/stft_frame_scheduler.sv
// stft_frame_scheduler
//   Collects the STFT input-stage sample stream into an FFT_SIZE-deep circular
//   window buffer. Every HOP new samples, once the window is full, it streams
//   one whole frame to the FFT engine, oldest sample first. It then waits for
//   the engine's completion pulse before it arms the next frame.
//
// Ports
//   clk            compute clock
//   RESET          synchronous, active-high reset
//   start_compute  one-cycle strobe qualifying i_sample
//   i_sample       signed input sample
//   fft_ready      FFT core accepts a word when high
//   fft_done       one-cycle pulse: FFT finished the current frame
//   o_fft_data     frame word to the FFT core
//   o_fft_valid    o_fft_data valid; a transfer is valid && ready
//   o_fft_last     marks the final word of a frame
//   o_frame_start  one-cycle pulse when a frame is armed
//   o_busy         high while streaming or waiting for fft_done
//   o_overrun      sticky: a frame trigger arrived while busy and was dropped
//   o_frame_count  completed frames, wraps at 2^16
module stft_frame_scheduler #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned FFT_SIZE   = 256,
  parameter int unsigned HOP        = 64,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic                         clk,
  input  logic                         RESET,
  input  logic                         start_compute,
  input  logic signed [WORD_WIDTH-1:0] i_sample,
  input  logic                         fft_ready,
  input  logic                         fft_done,
  output logic signed [WORD_WIDTH-1:0] o_fft_data,
  output logic                         o_fft_valid,
  output logic                         o_fft_last,
  output logic                         o_frame_start,
  output logic                         o_busy,
  output logic                         o_overrun,
  output logic [15:0]                  o_frame_count
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam int unsigned HopW = $clog2(HOP + 1);
  localparam logic [CntW-1:0] FillFull = CntW'(FFT_SIZE);
  localparam logic [CntW-1:0] LastBeat = CntW'(FFT_SIZE - 1);
  localparam logic [HopW-1:0] HopMax   = HopW'(HOP);

  typedef enum logic [1:0] {StIdle, StStream, StWaitDone} state_e;

  state_e state_q, state_d;

  logic [WORD_WIDTH-1:0] mem [FFT_SIZE];

  logic [ADDR_W-1:0]     wr_ptr_q;
  logic [ADDR_W-1:0]     rd_ptr_q;
  logic [CntW-1:0]       fill_cnt_q;
  logic [HopW-1:0]       hop_cnt_q;
  logic [CntW-1:0]       issue_cnt_q;   // words fetched from the buffer this frame
  logic [WORD_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  last_q;
  logic                  frame_start_q;
  logic                  overrun_q;
  logic [15:0]           frame_count_q;

  logic trigger;
  logic xfer;
  logic last_xfer;
  logic issue_done;
  logic start_frame;
  logic overrun_set;
  logic load;
  logic frame_done;
  logic busy;

  assign trigger    = (fill_cnt_q == FillFull) && (hop_cnt_q == HopMax);
  assign xfer       = valid_q && fft_ready;
  assign last_xfer  = xfer && last_q;
  assign issue_done = (issue_cnt_q == FillFull);

  // State register
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (trigger)   state_d = StStream;
      StStream:   if (last_xfer) state_d = StWaitDone;
      StWaitDone: if (fft_done)  state_d = StIdle;
      default:                   state_d = StIdle;
    endcase
  end

  // Per-state control decode
  always_comb begin
    start_frame = 1'b0;
    overrun_set = 1'b0;
    load        = 1'b0;
    frame_done  = 1'b0;
    busy        = 1'b0;
    unique case (state_q)
      StIdle: begin
        start_frame = trigger;
      end
      StStream: begin
        busy        = 1'b1;
        overrun_set = trigger;
        // Refill the output register when it is empty or being drained.
        load        = !issue_done && (!valid_q || fft_ready);
      end
      StWaitDone: begin
        busy        = 1'b1;
        overrun_set = trigger;
        frame_done  = fft_done;
      end
      default: ;
    endcase
  end

  // Window buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (start_compute) begin
      mem[wr_ptr_q] <= i_sample;
    end
  end

  // Write-side counters, read pipeline and status registers
  always_ff @(posedge clk) begin
    if (RESET) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fill_cnt_q    <= '0;
      hop_cnt_q     <= '0;
      issue_cnt_q   <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      frame_start_q <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      if (start_compute) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (fill_cnt_q != FillFull) begin
          fill_cnt_q <= fill_cnt_q + 1'b1;
        end
      end

      // A trigger restarts the hop count; a coincident write counts as the first.
      if (trigger) begin
        hop_cnt_q <= start_compute ? HopW'(1) : '0;
      end else if (start_compute && (hop_cnt_q != HopMax)) begin
        hop_cnt_q <= hop_cnt_q + 1'b1;
      end

      frame_start_q <= start_frame;

      if (start_frame) begin
        rd_ptr_q    <= wr_ptr_q;
        issue_cnt_q <= '0;
      end else if (load) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        issue_cnt_q <= issue_cnt_q + 1'b1;
      end

      // Synchronous read straight into the output register; the NBA on mem
      // makes a same-address write land after this read.
      if (load) begin
        data_q  <= mem[rd_ptr_q];
        valid_q <= 1'b1;
        last_q  <= (issue_cnt_q == LastBeat);
      end else if (xfer) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end

      if (overrun_set) begin
        overrun_q <= 1'b1;
      end

      if (frame_done) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  assign o_fft_data    = data_q;
  assign o_fft_valid   = valid_q;
  assign o_fft_last    = last_q;
  assign o_frame_start = frame_start_q;
  assign o_busy        = busy;
  assign o_overrun     = overrun_q;
  assign o_frame_count = frame_count_q;

endmodule

// File: tb/tb_stft_frame_scheduler.sv
// Self-checking bench for stft_frame_scheduler. A reference model keeps the
// sample history and the fill/hop rules, and predicts each frame as the last
// FFT_SIZE samples at trigger time; a negedge monitor scores every transfer.
module tb_stft_frame_scheduler;

  localparam int N   = 256;
  localparam int HOP = 64;

  logic        clk = 1'b0;
  logic        RESET;
  logic        start_compute;
  logic [15:0] i_sample;
  logic        fft_ready;
  logic        fft_done;
  logic [15:0] o_fft_data;
  logic        o_fft_valid;
  logic        o_fft_last;
  logic        o_frame_start;
  logic        o_busy;
  logic        o_overrun;
  logic [15:0] o_frame_count;

  always #5 clk = ~clk;

  stft_frame_scheduler #(
    .WORD_WIDTH(16),
    .FFT_SIZE  (N),
    .HOP       (HOP),
    .ADDR_W    (8)
  ) dut (
    .clk          (clk),
    .RESET        (RESET),
    .start_compute(start_compute),
    .i_sample     (i_sample),
    .fft_ready    (fft_ready),
    .fft_done     (fft_done),
    .o_fft_data   (o_fft_data),
    .o_fft_valid  (o_fft_valid),
    .o_fft_last   (o_fft_last),
    .o_frame_start(o_frame_start),
    .o_busy       (o_busy),
    .o_overrun    (o_overrun),
    .o_frame_count(o_frame_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [15:0] hist[$];
  logic [15:0] exp_q[$];
  int  m_fill, m_hop, m_starts, m_frame_count, m_completed;
  bit  m_busy, m_overrun;

  // Monitor state
  int  seen_starts = 0;
  int  starts_base = 0;
  int  beat_idx = 0;
  int  frames_completed = 0;
  bit  start_prev = 0;
  bit  prev_stall = 0;
  logic [15:0] prev_data;
  logic        prev_last;

  // Ready pattern: 0 always high, 1 repeating 1,0,0, 2 random
  int rdy_mode = 0;
  int rdy_phase = 0;

  initial begin
    fft_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: fft_ready = 1'b1;
        1: begin
          fft_ready = (rdy_phase == 0);
          rdy_phase = (rdy_phase + 1) % 3;
        end
        default: fft_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (RESET) begin
      beat_idx   = 0;
      start_prev = 0;
      prev_stall = 0;
    end else begin
      if (start_prev) begin
        check_eq("first_valid_latency", o_fft_valid, 1);
        check_eq("frame_start_one_cycle", o_frame_start, 0);
      end
      if (o_frame_start) begin
        seen_starts++;
        beat_idx = 0;
        check_eq("busy_at_start", o_busy, 1);
      end
      start_prev = o_frame_start;
      if (prev_stall) begin
        check_eq("stall_hold_valid", o_fft_valid, 1);
        check_eq("stall_hold_data", o_fft_data, prev_data);
        check_eq("stall_hold_last", o_fft_last, prev_last);
      end
      if (o_fft_valid && fft_ready) begin
        check_eq("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check_eq("beat_data", o_fft_data, e);
          check_eq("beat_last", o_fft_last, beat_idx == N - 1);
        end
        beat_idx++;
        if (beat_idx == N) frames_completed++;
      end
      prev_stall = o_fft_valid && !fft_ready;
      prev_data  = o_fft_data;
      prev_last  = o_fft_last;
    end
  end

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    m_fill = 0;
    m_hop = 0;
    m_starts = 0;
    m_frame_count = 0;
    m_busy = 0;
    m_overrun = 0;
    starts_base = seen_starts;
  endtask

  // One write, followed by at least one idle cycle.
  task automatic write_sample(input logic [15:0] v);
    @(posedge clk);
    #1;
    start_compute = 1'b1;
    i_sample = v;
    @(posedge clk);
    #1;
    start_compute = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    hist.push_back(v);
    if (hist.size() > N) void'(hist.pop_front());
    if (m_fill < N) m_fill++;
    if (m_hop < HOP) m_hop++;
    if (m_fill == N && m_hop == HOP) begin
      m_hop = 0;
      if (!m_busy) begin
        m_busy = 1;
        m_starts++;
        m_completed++;
        foreach (hist[i]) exp_q.push_back(hist[i]);
      end else begin
        m_overrun = 1;
      end
    end
  endtask

  task automatic write_random(input int n);
    for (int i = 0; i < n; i++) write_sample(16'($urandom));
  endtask

  task automatic wait_frames(input string tag);
    int n = 0;
    while (frames_completed < m_completed && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq({tag, "_frame_done"}, frames_completed, m_completed);
    check_eq({tag, "_no_missing_beats"}, exp_q.size(), 0);
    check_eq({tag, "_starts"}, seen_starts - starts_base, m_starts);
  endtask

  task automatic wait_beat(input int b);
    int n = 0;
    while (beat_idx < b && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("beat_wait", beat_idx >= b, 1);
  endtask

  task automatic pulse_done(input string tag);
    @(posedge clk);
    #1;
    fft_done = 1'b1;
    @(posedge clk);
    #1;
    fft_done = 1'b0;
    m_busy = 0;
    m_frame_count++;
    check_eq({tag, "_frame_count"}, o_frame_count, m_frame_count);
    check_eq({tag, "_idle"}, o_busy, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_data"}, o_fft_data, 0);
    check_eq({tag, "_valid"}, o_fft_valid, 0);
    check_eq({tag, "_last"}, o_fft_last, 0);
    check_eq({tag, "_start"}, o_frame_start, 0);
    check_eq({tag, "_busy"}, o_busy, 0);
    check_eq({tag, "_overrun"}, o_overrun, 0);
    check_eq({tag, "_count"}, o_frame_count, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    start_compute = 1'b0;
    i_sample = '0;
    fft_done = 1'b0;
    m_completed = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    RESET = 1'b0;

    // Ramp 0..255 with ready held high
    rdy_mode = 0;
    for (int i = 0; i < N; i++) write_sample(16'(i));
    wait_frames("ramp");
    pulse_done("ramp");

    // 64 more samples: frame 64..319 under random ready
    rdy_mode = 2;
    for (int i = N; i < N + HOP; i++) write_sample(16'(i));
    wait_frames("hop");
    pulse_done("hop");

    // Ready 1,0,0 stalls; a done pulse mid-stream must be ignored
    rdy_mode = 1;
    write_random(HOP);
    wait_beat(50);
    @(posedge clk);
    #1;
    fft_done = 1'b1;
    @(posedge clk);
    #1;
    fft_done = 1'b0;
    check_eq("done_in_stream_count", o_frame_count, m_frame_count);
    check_eq("done_in_stream_busy", o_busy, 1);
    wait_frames("stall");

    // fft_done withheld: the next trigger is dropped
    check_eq("overrun_before", o_overrun, 0);
    rdy_mode = 2;
    write_random(HOP);
    repeat (5) @(posedge clk);
    #1;
    check_eq("overrun_set", o_overrun, m_overrun);
    check_eq("overrun_no_start", seen_starts - starts_base, m_starts);
    check_eq("overrun_still_busy", o_busy, 1);
    pulse_done("overrun");
    check_eq("overrun_sticky", o_overrun, 1);

    // Next frame carries the latest 256 samples; abort it at beat 100
    rdy_mode = 0;
    write_random(HOP);
    wait_beat(100);
    @(posedge clk);
    #1;
    RESET = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_outputs_zero("abort");
    RESET = 1'b0;
    m_completed = frames_completed;
    model_reset();

    // Refill from empty; 16'h8000 becomes beat 0 of the next frame
    rdy_mode = 2;
    write_sample(16'h8000);
    write_random(N - 2);
    repeat (10) @(posedge clk);
    #1;
    check_eq("refill_no_start", seen_starts - starts_base, 0);
    check_eq("refill_idle", o_busy, 0);
    write_random(1);
    wait_frames("min_word");
    pulse_done("min_word");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
